// File: rtl/core_pipe_fetch_ctrl_pkg.sv
// Shared fetch-stage types: address width default, halfword-offset type and
// the mapping from fetch offset to one-hot buffer fill size.
package core_pipe_fetch_ctrl_pkg;

   localparam int CORE_XLEN   = 64;
   localparam int FETCH_OFF_W = 2;

   typedef logic [FETCH_OFF_W-1:0] fetch_off_t;

   typedef struct packed {
      logic fill_2;
      logic fill_4;
      logic fill_6;
      logic fill_8;
   } fill_sel_t;

   localparam fill_sel_t FILL_NONE = '{fill_2: 1'b0, fill_4: 1'b0, fill_6: 1'b0, fill_8: 1'b0};

   // A fetch that starts at halfword offset N within the 8-byte beat only
   // contributes the bytes from that offset to the end of the beat.
   function automatic fill_sel_t off_to_fill(input fetch_off_t off);
      fill_sel_t sel;
      sel = FILL_NONE;
      case (off)
         2'd0:    sel.fill_8 = 1'b1;
         2'd1:    sel.fill_6 = 1'b1;
         2'd2:    sel.fill_4 = 1'b1;
         default: sel.fill_2 = 1'b1;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/core_fetch_pending_fifo.sv
// Small FIFO holding the halfword offset of every in-flight fetch request,
// oldest at the head; clear drops everything in one cycle.
module core_fetch_pending_fifo
   import core_pipe_fetch_ctrl_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       push_i,
   input  fetch_off_t push_data_i,
   input  logic       pop_i,
   input  logic       clear_i,
   output fetch_off_t head_o,
   output logic       full_o,
   output logic       empty_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   fetch_off_t    mem_q [0:(1<<PW)-1];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
         end
         if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage needs no reset: entries are only read while counted valid.
   always_ff @(posedge clk_i) begin
      if (do_push && !clear_i) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

endmodule

// File: rtl/core_pipe_fetch_ctrl.sv
// Fetch-stage controller: issues aligned 8-byte instruction fetches, tracks
// in-flight requests, turns responses into fetch-buffer fills, handles redirects.
module core_pipe_fetch_ctrl
   import core_pipe_fetch_ctrl_pkg::*;
#(
   parameter int               XLEN            = CORE_XLEN,
   parameter logic [XLEN-1:0]  RESET_PC        = XLEN'(64'h0000_0000_1000_0000),
   parameter int               MAX_OUTSTANDING = 2,
   parameter int               BUF_BYTES       = 16
) (
   input  logic            g_clk,
   input  logic            g_reset,
   input  logic            cf_req,
   input  logic [XLEN-1:0] cf_target,
   output logic            cf_ack,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_recv,
   output logic            imem_ack,
   input  logic [63:0]     imem_rdata,
   input  logic            imem_error,
   input  logic [4:0]      buf_depth,
   output logic            buf_flush,
   output logic            buf_fill_en,
   output logic [63:0]     buf_data,
   output logic            buf_error,
   output logic            buf_fill_2,
   output logic            buf_fill_4,
   output logic            buf_fill_6,
   output logic            buf_fill_8
);

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [1:0]      outstanding_q, outstanding_d;
   logic [1:0]      discard_q, discard_d;

   logic [2:0]      inflight;
   logic [6:0]      space_need;
   logic            req_ok;
   logic            grant;
   logic            resp_disc, resp_fill, resp_any;
   fetch_off_t      head_off;
   logic            fifo_full, fifo_empty;
   fill_sel_t       fill_sel;

   // Every in-flight request reserves a full 8-byte beat, whatever its offset.
   assign inflight   = {1'b0, outstanding_q} + {1'b0, discard_q};
   assign space_need = {2'b00, buf_depth} + {1'b0, ({1'b0, outstanding_q} + 3'd1), 3'b000};
   assign req_ok     = (inflight < 3'(MAX_OUTSTANDING)) && (space_need <= 7'(BUF_BYTES));

   assign imem_req  = !g_reset && req_ok;
   assign imem_addr = {fetch_pc_q[XLEN-1:3], 3'b000};
   assign imem_ack  = 1'b1;
   assign grant     = imem_req && imem_gnt;

   // A redirect must not abandon a request the memory has not yet taken.
   assign cf_ack    = !g_reset && cf_req && (!imem_req || imem_gnt);
   assign buf_flush = cf_ack;

   assign resp_disc = imem_recv && (discard_q != 2'd0);
   assign resp_fill = imem_recv && (discard_q == 2'd0) && (outstanding_q != 2'd0);
   assign resp_any  = resp_disc || resp_fill;

   assign buf_fill_en = !g_reset && resp_fill && !cf_ack;
   assign fill_sel    = buf_fill_en ? off_to_fill(head_off) : FILL_NONE;
   assign buf_fill_2  = fill_sel.fill_2;
   assign buf_fill_4  = fill_sel.fill_4;
   assign buf_fill_6  = fill_sel.fill_6;
   assign buf_fill_8  = fill_sel.fill_8;
   assign buf_data    = imem_rdata;
   assign buf_error   = imem_error;

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      outstanding_d = outstanding_q;
      discard_d     = discard_q;
      if (cf_ack) begin
         // Everything still in flight, including a request granted right now,
         // becomes stale and must be swallowed when it returns.
         fetch_pc_d    = {cf_target[XLEN-1:1], 1'b0};
         outstanding_d = 2'd0;
         discard_d     = discard_q + outstanding_q + 2'(grant) - 2'(resp_any);
      end else begin
         if (grant) begin
            fetch_pc_d = imem_addr + XLEN'(8);
         end
         outstanding_d = outstanding_q + 2'(grant) - 2'(resp_fill);
         if (resp_disc) begin
            discard_d = discard_q - 2'd1;
         end
      end
   end

   always_ff @(posedge g_clk) begin
      if (g_reset) begin
         fetch_pc_q    <= RESET_PC;
         outstanding_q <= 2'd0;
         discard_q     <= 2'd0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
      end
   end

   core_fetch_pending_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_pending (
      .clk_i       (g_clk),
      .rst_i       (g_reset),
      .push_i      (grant && !cf_ack),
      .push_data_i (fetch_pc_q[2:1]),
      .pop_i       (buf_fill_en),
      .clear_i     (cf_ack),
      .head_o      (head_off),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   logic unused_flags;
   assign unused_flags = fifo_full ^ fifo_empty;

endmodule

// File: tb/tb_core_pipe_fetch_ctrl.sv
// Bench for the fetch controller: directed scenarios with literal checks plus
// a per-cycle comparison against a queue-based model of the fetch rules.
module tb_core_pipe_fetch_ctrl;

   localparam logic [63:0] RESET_PC  = 64'h0000_0000_1000_0000;
   localparam int          MAX_OUT   = 2;
   localparam int          BUF_BYTES = 16;

   logic        g_clk = 1'b0;
   logic        g_reset;
   logic        cf_req;
   logic [63:0] cf_target;
   logic        cf_ack;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_gnt;
   logic        imem_recv;
   logic        imem_ack;
   logic [63:0] imem_rdata;
   logic        imem_error;
   logic [4:0]  buf_depth;
   logic        buf_flush;
   logic        buf_fill_en;
   logic [63:0] buf_data;
   logic        buf_error;
   logic        buf_fill_2, buf_fill_4, buf_fill_6, buf_fill_8;

   int errors = 0;
   int checks = 0;

   // Model state: program counter, stale-response count, offsets of live requests.
   logic [63:0] m_pc;
   int          m_disc;
   int          m_pend[$];

   core_pipe_fetch_ctrl dut (
      .g_clk       (g_clk),
      .g_reset     (g_reset),
      .cf_req      (cf_req),
      .cf_target   (cf_target),
      .cf_ack      (cf_ack),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_recv   (imem_recv),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .imem_error  (imem_error),
      .buf_depth   (buf_depth),
      .buf_flush   (buf_flush),
      .buf_fill_en (buf_fill_en),
      .buf_data    (buf_data),
      .buf_error   (buf_error),
      .buf_fill_2  (buf_fill_2),
      .buf_fill_4  (buf_fill_4),
      .buf_fill_6  (buf_fill_6),
      .buf_fill_8  (buf_fill_8)
   );

   always #5 g_clk = ~g_clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model, then advance the model to the next edge.
   always @(negedge g_clk) begin : compare
      int   outs, fsz;
      logic e_req, e_ack, e_fill, grant, r_disc, r_fill;
      if (g_reset) begin
         chk("m_rst_req",   imem_req,    1'b0);
         chk("m_rst_ack",   cf_ack,      1'b0);
         chk("m_rst_flush", buf_flush,   1'b0);
         chk("m_rst_fill",  buf_fill_en, 1'b0);
         chk("m_rst_sizes", {buf_fill_2, buf_fill_4, buf_fill_6, buf_fill_8}, 4'b0);
         chk("m_rst_iack",  imem_ack,    1'b1);
         m_pc   = RESET_PC;
         m_disc = 0;
         m_pend.delete();
      end else begin
         outs   = m_pend.size();
         e_req  = (outs + m_disc < MAX_OUT) && (int'(buf_depth) + 8 * (outs + 1) <= BUF_BYTES);
         e_ack  = cf_req && (!e_req || imem_gnt);
         grant  = e_req && imem_gnt;
         r_disc = imem_recv && (m_disc > 0);
         r_fill = imem_recv && (m_disc == 0) && (outs > 0);
         e_fill = r_fill && !e_ack;
         fsz    = e_fill ? 8 - 2 * m_pend[0] : 0;
         chk("m_req",   imem_req,    e_req);
         if (e_req) chk("m_addr", imem_addr, m_pc & ~64'h7);
         chk("m_cfack", cf_ack,      e_ack);
         chk("m_flush", buf_flush,   e_ack);
         chk("m_fill",  buf_fill_en, e_fill);
         chk("m_sizes", {buf_fill_2, buf_fill_4, buf_fill_6, buf_fill_8},
             {fsz == 2, fsz == 4, fsz == 6, fsz == 8});
         chk("m_data",  buf_data,    imem_rdata);
         chk("m_err",   buf_error,   imem_error);
         chk("m_iack",  imem_ack,    1'b1);
         if (e_ack) begin
            m_disc = m_disc + outs + (grant ? 1 : 0) - ((r_disc || r_fill) ? 1 : 0);
            m_pend.delete();
            m_pc = cf_target & ~64'h1;
         end else begin
            if (r_fill) void'(m_pend.pop_front());
            if (r_disc) m_disc--;
            if (grant) begin
               m_pend.push_back(int'(m_pc[2:1]));
               m_pc = (m_pc & ~64'h7) + 64'd8;
            end
         end
      end
   end

   task automatic settle();
      @(negedge g_clk);
   endtask

   task automatic advance();
      @(posedge g_clk);
      #1;
   endtask

   task automatic drive(input bit gnt, input bit recv, input bit cfr, input logic [63:0] tgt,
                        input int depth, input bit err, input logic [63:0] rdata);
      imem_gnt   = gnt;
      imem_recv  = recv;
      cf_req     = cfr;
      cf_target  = tgt;
      buf_depth  = 5'(depth);
      imem_error = err;
      imem_rdata = rdata;
   endtask

   initial begin
      g_reset = 1'b1;
      drive(0, 0, 0, 64'h0, 0, 0, 64'h0);
      settle();
      chk("rst_req",  imem_req, 1'b0);
      chk("rst_iack", imem_ack, 1'b1);
      advance();
      settle();
      advance();
      g_reset = 1'b0;

      // Two back-to-back fetches, then held off at the outstanding limit.
      drive(1, 0, 0, 64'h0, 0, 0, 64'h0);
      settle(); chk("a_req", imem_req, 1'b1); chk("a_addr", imem_addr, 64'h1000_0000); advance();
      settle(); chk("b_req", imem_req, 1'b1); chk("b_addr", imem_addr, 64'h1000_0008); advance();
      settle(); chk("c_req_held", imem_req, 1'b0); advance();
      drive(1, 1, 0, 64'h0, 0, 0, 64'h1111_2222_3333_4444);
      settle(); chk("d_fill", buf_fill_en, 1'b1); chk("d_f8", buf_fill_8, 1'b1);
      chk("d_data", buf_data, 64'h1111_2222_3333_4444); advance();
      drive(1, 0, 0, 64'h0, 0, 0, 64'h0);
      settle(); chk("e_addr", imem_addr, 64'h1000_0010); advance();

      // Redirect with two outstanding: both old responses are swallowed.
      drive(1, 0, 1, 64'h2000_0006, 0, 0, 64'h0);
      settle(); chk("f_ack", cf_ack, 1'b1); chk("f_flush", buf_flush, 1'b1); advance();
      drive(1, 1, 0, 64'h0, 0, 0, 64'h5);
      settle(); chk("g_fill", buf_fill_en, 1'b0); chk("g_req", imem_req, 1'b0); advance();
      settle(); chk("h_addr", imem_addr, 64'h2000_0000); chk("h_fill", buf_fill_en, 1'b0); advance();
      settle(); chk("i_f2", buf_fill_2, 1'b1); chk("i_fill", buf_fill_en, 1'b1);
      chk("i_addr", imem_addr, 64'h2000_0008); advance();
      drive(0, 1, 0, 64'h0, 0, 0, 64'h6);
      settle(); chk("j_f8", buf_fill_8, 1'b1); advance();

      // Redirect waits for the pending request to be granted.
      drive(0, 0, 1, 64'h3000_0000, 0, 0, 64'h0);
      settle(); chk("k_ack_wait", cf_ack, 1'b0); advance();
      drive(1, 0, 1, 64'h3000_0000, 0, 0, 64'h0);
      settle(); chk("l_ack", cf_ack, 1'b1); advance();
      drive(1, 0, 0, 64'h0, 0, 0, 64'h0);
      settle(); chk("m_addr_new", imem_addr, 64'h3000_0000); advance();
      drive(1, 1, 0, 64'h0, 0, 0, 64'h7);
      settle(); chk("n_drop", buf_fill_en, 1'b0); chk("n_req", imem_req, 1'b0); advance();
      drive(1, 0, 0, 64'h0, 0, 0, 64'h0);
      settle(); chk("n2_addr", imem_addr, 64'h3000_0008); advance();

      // Response coincident with redirect, then space-limited issue.
      drive(0, 1, 1, 64'h4000_0003, 16, 0, 64'h8);
      settle(); chk("o_ack", cf_ack, 1'b1); chk("o_fill", buf_fill_en, 1'b0); advance();
      drive(0, 1, 0, 64'h0, 10, 0, 64'h9);
      settle(); chk("p_req", imem_req, 1'b0); chk("p_fill", buf_fill_en, 1'b0); advance();
      drive(1, 0, 0, 64'h0, 10, 0, 64'h0);
      settle(); chk("q_req_full", imem_req, 1'b0); advance();
      drive(1, 0, 0, 64'h0, 8, 0, 64'h0);
      settle(); chk("r_req", imem_req, 1'b1); chk("r_addr", imem_addr, 64'h4000_0000); advance();
      drive(1, 0, 0, 64'h0, 0, 0, 64'h0);
      settle(); chk("s_req", imem_req, 1'b1); chk("s_addr", imem_addr, 64'h4000_0008); advance();

      // Error-tagged response keeps its fill size; fetching continues.
      drive(0, 1, 0, 64'h0, 0, 1, 64'hDEAD_BEEF_0BAD_F00D);
      settle(); chk("t_f6", buf_fill_6, 1'b1); chk("t_err", buf_error, 1'b1); advance();
      drive(1, 1, 0, 64'h0, 0, 0, 64'h0123_4567_89AB_CDEF);
      settle(); chk("u_f8", buf_fill_8, 1'b1); chk("u_addr", imem_addr, 64'h4000_0010); advance();
      drive(0, 1, 0, 64'h0, 0, 0, 64'h1);
      settle(); chk("v_f8", buf_fill_8, 1'b1); chk("v_addr", imem_addr, 64'h4000_0018); advance();
      drive(0, 1, 0, 64'h0, 0, 0, 64'h2);
      settle(); chk("w_orphan", buf_fill_en, 1'b0); advance();

      // Mixed traffic checked by the model alone.
      for (int i = 0; i < 300; i++) begin
         drive(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
               {$urandom, $urandom}, $urandom_range(0, 20), 1'($urandom_range(0, 1)),
               {$urandom, $urandom});
         settle();
         advance();
      end

      drive(0, 0, 0, 64'h0, 0, 0, 64'h0);
      settle();
      advance();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
